// File: rtl/rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
// rr_grant_ctrl : round-robin one-hot grant with hold-until-release (opt. RR_TIMEOUT_EN)
// Rev 1.0
// ============================================================================
module rr_grant_ctrl #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           gnt,
  output logic                       gnt_valid,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       timeout
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (N_REQ < 2 || N_REQ > 16) begin : g_check_n_req
    $error("rr_grant_ctrl: N_REQ out of range");
  end
  if (HOLD_MAX < 2) begin : g_check_hold_max
    $error("rr_grant_ctrl: HOLD_MAX must be at least 2");
  end

  logic [0:0]       state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   pick_id, gnt_id_nxt;
  logic             pick_found;
  logic [N_REQ-1:0] gnt_nxt;
  logic             gnt_valid_nxt;
  logic             rel_normal;
  logic             rel_force;
  logic             rel;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDW-1:0];
  endfunction

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    logic [IDW-1:0] cand;
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = wrap_add(ptr, i);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign rel_normal = (state == S_GRANT) && (done[gnt_id] || !req[gnt_id]);
  assign rel        = rel_normal || rel_force;

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX);

  logic [CW-1:0] hold_cnt;
  logic          timeout_r;

  assign rel_force = (state == S_GRANT) && !rel_normal && (hold_cnt == CW'(HOLD_MAX - 1));

  // Held at zero while idle, so it is already cleared on entry to GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= rel_force;
      if (state == S_IDLE || rel) begin
        hold_cnt <= '0;
      end else if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

  assign timeout = timeout_r;
`else
  assign rel_force = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      gnt_id    <= gnt_id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_found) state_nxt = S_GRANT;
      S_GRANT: if (rel)        state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    gnt_id_nxt    = gnt_id;
    ptr_nxt       = ptr;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          gnt_nxt       = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
          gnt_valid_nxt = 1'b1;
          gnt_id_nxt    = pick_id;
        end
      end
      S_GRANT: begin
        // The departing owner becomes lowest priority for the next scan.
        if (rel) begin
          gnt_nxt       = '0;
          gnt_valid_nxt = 1'b0;
          ptr_nxt       = wrap_add(gnt_id, 1);
        end
      end
      default: begin
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rr_grant_ctrl : directed stimulus, behavioural model compared every cycle
// ============================================================================
module tb_rr_grant_ctrl;

  localparam int N    = 4;
  localparam int HOLD = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [N-1:0] req  = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_grant_ctrl #(.N_REQ(N), .HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 when idle; hold counts GRANT cycles served so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1; m_ptr = 0; m_last = 0; m_hold = 0; m_to = 1'b0;
      end else begin
        m_to = 1'b0;
        if (m_owner < 0) begin
          for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % N]) begin
              m_owner = (m_ptr + k) % N;
              m_last  = m_owner;
              m_hold  = 1;
            end
          end
        end else if (done[m_owner] || !req[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end else if (TO_EN && m_hold == HOLD) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_to    = 1'b1;
        end else begin
          m_hold++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
      check("model_gnt_id",    32'(gnt_id),    32'(m_last));
      check("model_timeout",   32'(timeout),   32'(m_to));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id, input logic to);
    check({tag, "_gnt"},       32'(gnt),       32'(g));
    check({tag, "_gnt_valid"}, 32'(gnt_valid), 32'(|g));
    check({tag, "_gnt_id"},    32'(gnt_id),    32'(id));
    check({tag, "_timeout"},   32'(timeout),   32'(to));
  endtask

  initial begin
    int ord [5];
    logic [3:0] g;
    ord = '{0, 1, 2, 3, 0};

    #1 rst = 1'b1;
    #2 expect_out("reset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Rotation with all requesters persistent
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << ord[i];
      step(); expect_out("rot_grant", g, 2'(ord[i]), 1'b0);
      done = g;
      step(); expect_out("rot_bubble", 4'b0000, 2'(ord[i]), 1'b0);
      done = '0;
    end
    req = '0;

    // Single requester, release on third grant cycle
    req = 4'b0010;
    step(); expect_out("single_c1", 4'b0010, 2'd1, 1'b0);
    step(); expect_out("single_c2", 4'b0010, 2'd1, 1'b0);
    step(); expect_out("single_c3", 4'b0010, 2'd1, 1'b0);
    done = 4'b0010;
    step(); expect_out("single_rel", 4'b0000, 2'd1, 1'b0);
    done = '0; req = '0;

    // ptr=2 then wrap and skip
    req = 4'b0101;
    step(); expect_out("ptr2_grant", 4'b0100, 2'd2, 1'b0);
    done = 4'b0100;
    step(); expect_out("ptr2_rel", 4'b0000, 2'd2, 1'b0);
    done = '0;
    step(); expect_out("wrap_g0", 4'b0001, 2'd0, 1'b0);
    done = 4'b0001;
    step(); expect_out("wrap_rel0", 4'b0000, 2'd0, 1'b0);
    done = '0;
    step(); expect_out("wrap_g2", 4'b0100, 2'd2, 1'b0);
    done = 4'b0100;
    step(); expect_out("wrap_rel2", 4'b0000, 2'd2, 1'b0);
    done = '0;
    step(); expect_out("wrap_g0b", 4'b0001, 2'd0, 1'b0);

    // Non-owner done has no effect; owner req drop releases
    done = 4'b0100;
    step(); expect_out("nonowner_done", 4'b0001, 2'd0, 1'b0);
    req = 4'b0100;
    step(); expect_out("req_drop_rel", 4'b0000, 2'd0, 1'b0);
    done = '0;
    step(); expect_out("after_drop_g2", 4'b0100, 2'd2, 1'b0);

    // Asynchronous reset mid-grant
    rst = 1'b1;
    #1 expect_out("async_rst", 4'b0000, 2'd0, 1'b0);
    req = 4'b0001;
    step(); expect_out("rst_held", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    step(); expect_out("post_rst_g0", 4'b0001, 2'd0, 1'b0);
    done = 4'b0001;
    step(); expect_out("post_rst_rel", 4'b0000, 2'd0, 1'b0);
    done = '0; req = '0;

    // Hold / timeout scenario from ptr=0
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'b0011;
    step(); expect_out("hold_c1", 4'b0001, 2'd0, 1'b0);
    step(); expect_out("hold_c2", 4'b0001, 2'd0, 1'b0);
    step(); expect_out("hold_c3", 4'b0001, 2'd0, 1'b0);
    step(); expect_out("hold_c4", 4'b0001, 2'd0, 1'b0);
    step();
    if (TO_EN) expect_out("timeout_rel", 4'b0000, 2'd0, 1'b1);
    else       expect_out("hold_c5", 4'b0001, 2'd0, 1'b0);
    step();
    if (TO_EN) expect_out("timeout_next_g1", 4'b0010, 2'd1, 1'b0);
    else       expect_out("hold_c6", 4'b0001, 2'd0, 1'b0);
    done = TO_EN ? 4'b0010 : 4'b0001;
    step();
    if (TO_EN) expect_out("final_rel", 4'b0000, 2'd1, 1'b0);
    else       expect_out("final_rel", 4'b0000, 2'd0, 1'b0);
    done = '0; req = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
